// File: rtl/imem_pkg.sv
// Shared types and elaboration helpers for the clocked instruction memory.
package imem_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_OOB      = 2'd2
  } fault_e;

  function automatic bit latency_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage, one write port, one registered read port; no storage reset.
module imem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read returns the old word on a same-address collision; the bank bypasses it.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_bank.sv
// Instruction memory bank: post-reset clear, pipelined fetch with fault codes,
// and a checked program port with write-first bypass into the fetch path.
module imem_bank
  import imem_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic [1:0]        fetch_fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_err,
  output logic              init_done
);

  localparam int AW = $clog2(DEPTH);

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("imem_bank: LATENCY must be 1 or 2");
  end

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_q, clr_d;
  logic            ready;

  // Without clearing, INIT lasts a single edge so ready still reads 0 in reset.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    case (state_q)
      ST_INIT: begin
        if (CLEAR_ON_RESET == 0) begin
          state_d = ST_READY;
        end else begin
          clr_d = clr_q + AW'(1);
          if (clr_q == AW'(DEPTH - 1)) state_d = ST_READY;
        end
      end
      default: state_d = state_q;
    endcase
  end

  assign ready       = (state_q == ST_READY);
  assign fetch_ready = ready;
  assign init_done   = ready;

  logic          f_mis, f_oob, p_mis, p_oob;
  logic [AW-1:0] f_idx, p_idx;
  logic          accept, prog_ok, byp, err_d;
  fault_e        flt_d;

  assign f_mis = |fetch_addr[1:0];
  assign f_oob = |fetch_addr[ADDR_W-1:AW+2];
  assign f_idx = fetch_addr[AW+1:2];
  assign p_mis = |prog_addr[1:0];
  assign p_oob = |prog_addr[ADDR_W-1:AW+2];
  assign p_idx = prog_addr[AW+1:2];

  assign accept  = fetch_req && ready;
  assign prog_ok = prog_we && ready && !p_mis && !p_oob;
  assign err_d   = prog_we && !prog_ok;
  assign byp     = prog_ok && accept && (p_idx == f_idx);

  always_comb begin
    flt_d = FAULT_NONE;
    if (f_mis)      flt_d = FAULT_MISALIGN;
    else if (f_oob) flt_d = FAULT_OOB;
  end

  logic              arr_we;
  logic [AW-1:0]     arr_waddr;
  logic [DATA_W-1:0] arr_wdata, rdata;

  assign arr_we    = ((state_q == ST_INIT) && (CLEAR_ON_RESET != 0)) || prog_ok;
  assign arr_waddr = ready ? p_idx : clr_q;
  assign arr_wdata = ready ? prog_data : '0;

  imem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .raddr_i (f_idx),
    .rdata_o (rdata)
  );

  logic              vld1_q, byp1_q, err_q;
  fault_e            flt1_q;
  logic [DATA_W-1:0] bypd_q, s1_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      clr_q   <= '0;
      vld1_q  <= 1'b0;
      flt1_q  <= FAULT_NONE;
      byp1_q  <= 1'b0;
      bypd_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      vld1_q  <= accept;
      flt1_q  <= accept ? flt_d : FAULT_NONE;
      byp1_q  <= byp;
      bypd_q  <= prog_data;
      err_q   <= err_d;
    end
  end

  assign prog_err = err_q;
  assign s1_data  = (!vld1_q || (flt1_q != FAULT_NONE)) ? '0 :
                    byp1_q ? bypd_q : rdata;

  if (LATENCY == 2) begin : g_lat2
    logic              vld2_q;
    logic [DATA_W-1:0] data2_q;
    fault_e            flt2_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld2_q  <= 1'b0;
        data2_q <= '0;
        flt2_q  <= FAULT_NONE;
      end else begin
        vld2_q  <= vld1_q;
        data2_q <= s1_data;
        flt2_q  <= flt1_q;
      end
    end

    assign fetch_valid = vld2_q;
    assign fetch_data  = data2_q;
    assign fetch_fault = flt2_q;
  end else begin : g_lat1
    assign fetch_valid = vld1_q;
    assign fetch_data  = s1_data;
    assign fetch_fault = flt1_q;
  end

endmodule

// File: tb/tb_imem_bank.sv
// Random + directed bench for imem_bank against a word-array model with
// per-latency response queues (LAT1 clear, LAT2 clear, LAT1 no-clear).
module tb_imem_bank;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        fetch_req, prog_we;
  logic [31:0] fetch_addr, prog_addr, prog_data;

  logic        rdy_a, vld_a, err_a, done_a;
  logic        rdy_b, vld_b, err_b, done_b;
  logic        rdy_c, vld_c, err_c, done_c;
  logic [31:0] dat_a, dat_b, dat_c;
  logic [1:0]  flt_a, flt_b, flt_c;

  imem_bank #(.DEPTH(D), .LATENCY(1), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(rdy_a), .fetch_valid(vld_a), .fetch_data(dat_a), .fetch_fault(flt_a),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_err(err_a), .init_done(done_a));

  imem_bank #(.DEPTH(D), .LATENCY(2), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(rdy_b), .fetch_valid(vld_b), .fetch_data(dat_b), .fetch_fault(flt_b),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_err(err_b), .init_done(done_b));

  imem_bank #(.DEPTH(D), .LATENCY(1), .CLEAR_ON_RESET(0)) u_c (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(rdy_c), .fetch_valid(vld_c), .fetch_data(dat_c), .fetch_fault(flt_c),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_err(err_c), .init_done(done_c));

  typedef struct {
    int          due;
    logic [31:0] d;
    logic [1:0]  f;
  } resp_t;

  resp_t       q1[$], q2[$], q3[$];
  logic [31:0] mem [D];
  int          cyc, since, total, bad;
  logic        exp_err, exp_err_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fault_of(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 2'd1;
    if ((a >> 2) >= D) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] rnd_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return ($urandom_range(0, D - 1) << 2) | $urandom_range(1, 3);
    if (k == 1) return $urandom_range(D, 1 << 20) << 2;
    if (k == 2) return $urandom | 32'h8000_0000;
    return $urandom_range(0, D - 1) << 2;
  endfunction

  task automatic reset_model();
    q1.delete(); q2.delete(); q3.delete();
    since = 0; exp_err = 1'b0; exp_err_c = 1'b0;
    for (int i = 0; i < D; i++) mem[i] = '0;
  endtask

  // which: 1 = LAT1 clear, 2 = LAT2 clear, 3 = LAT1 no-clear (data unknown unless faulted)
  task automatic chk_port(input string tag, input int which, input logic v,
                          input logic [31:0] d, input logic [1:0] f);
    resp_t e;
    bit    has;
    has = 0; e = '{0, 32'h0, 2'd0};
    if (which == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); has = 1; end
    if (which == 2 && q2.size() > 0 && q2[0].due == cyc) begin e = q2.pop_front(); has = 1; end
    if (which == 3 && q3.size() > 0 && q3[0].due == cyc) begin e = q3.pop_front(); has = 1; end
    chk({tag, ".valid"}, 32'(v), 32'(has));
    chk({tag, ".fault"}, 32'(f), 32'(e.f));
    if (which != 3 || !has || e.f != 2'd0) chk({tag, ".data"}, d, e.d);
  endtask

  task automatic step(input bit rst_after);
    bit          rdy, rdy3, pok;
    logic [1:0]  f;
    logic [31:0] d;
    rdy  = rst && (since >= D);
    rdy3 = rst && (since >= 1);
    pok  = prog_we && (fault_of(prog_addr) == 2'd0);
    exp_err   = rst && prog_we && !(rdy && pok);
    exp_err_c = rst && prog_we && !(rdy3 && pok);
    if (rdy && pok) mem[prog_addr[5:2]] = prog_data;
    f = fault_of(fetch_addr);
    if (fetch_req && rdy) begin
      d = (f == 2'd0) ? mem[fetch_addr[5:2]] : 32'h0;
      q1.push_back('{cyc + 1, d, f});
      q2.push_back('{cyc + 2, d, f});
    end
    if (fetch_req && rdy3) q3.push_back('{cyc + 1, 32'h0, f});
    @(posedge clk);
    cyc++;
    if (rst) since++;
    #1;
    if (rst_after) begin
      rst = 1'b0;
      reset_model();
      #1;
    end
    chk("a.ready", 32'(rdy_a), 32'(rst && since >= D));
    chk("a.init_done", 32'(done_a), 32'(rst && since >= D));
    chk("b.ready", 32'(rdy_b), 32'(rst && since >= D));
    chk("c.init_done", 32'(done_c), 32'(rst && since >= 1));
    chk("a.prog_err", 32'(err_a), 32'(exp_err));
    chk("b.prog_err", 32'(err_b), 32'(exp_err));
    chk("c.prog_err", 32'(err_c), 32'(exp_err_c));
    chk_port("a", 1, vld_a, dat_a, flt_a);
    chk_port("b", 2, vld_b, dat_b, flt_b);
    chk_port("c", 3, vld_c, dat_c, flt_c);
  endtask

  task automatic set_fetch(input logic req, input logic [31:0] a);
    fetch_req = req; fetch_addr = a;
  endtask

  task automatic set_prog(input logic we, input logic [31:0] a, input logic [31:0] dt);
    prog_we = we; prog_addr = a; prog_data = dt;
  endtask

  initial begin
    cyc = 0; total = 0; bad = 0;
    reset_model();
    set_fetch(1'b0, 32'h0);
    set_prog(1'b0, 32'h0, 32'h0);

    // Held in reset: every output at its reset value.
    repeat (3) step(0);
    rst = 1'b1;

    // INIT: fetches ignored, a write at 0x8 is rejected.
    set_fetch(1'b1, 32'h0);
    for (int i = 0; i < D; i++) begin
      if (i == 3) set_prog(1'b1, 32'h8, 32'h1234_5678);
      else        set_prog(1'b0, 32'h0, 32'h0);
      step(0);
    end
    set_prog(1'b0, 32'h0, 32'h0);

    // Cleared array sweep, back-to-back.
    for (int a = 0; a < 4 * D; a += 4) begin
      set_fetch(1'b1, 32'(a));
      step(0);
    end
    set_fetch(1'b0, 32'h0);
    repeat (2) step(0);

    set_prog(1'b1, 32'h0, 32'h0062_E233); step(0);
    set_prog(1'b1, 32'h4, 32'h0062_F433); step(0);
    set_prog(1'b0, 32'h0, 32'h0);
    set_fetch(1'b1, 32'h0);  step(0);
    set_fetch(1'b1, 32'h4);  step(0);
    set_fetch(1'b1, 32'h2);  step(0);
    set_fetch(1'b1, 32'h40); step(0);
    set_fetch(1'b1, 32'h42); step(0);
    set_prog(1'b1, 32'h8, 32'hDEAD_BEEF);
    set_fetch(1'b1, 32'h8);  step(0);
    set_prog(1'b0, 32'h0, 32'h0);
    step(0);
    set_fetch(1'b0, 32'h0);
    repeat (2) step(0);

    for (int i = 0; i < 400; i++) begin
      set_fetch(1'($urandom_range(0, 3) != 0), rnd_addr());
      set_prog(1'($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0) ? fetch_addr : rnd_addr(), $urandom);
      step(0);
    end
    set_fetch(1'b0, 32'h0);
    set_prog(1'b0, 32'h0, 32'h0);
    repeat (3) step(0);

    // Two fetches in flight, then reset: nothing may emerge.
    set_fetch(1'b1, 32'h0); step(0);
    set_fetch(1'b1, 32'h4); step(1);
    set_fetch(1'b1, 32'h0);
    repeat (3) step(0);
    rst = 1'b1;
    repeat (D + 3) step(0);
    set_fetch(1'b0, 32'h0);
    repeat (3) step(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
